// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO arbiter: FSM encoding, requester
// indices and the read-data pattern returned when the bus never answers.
package mio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mio_state_t;

    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

    localparam logic [31:0] TMO_PATTERN = 32'hDEAD_BEEF;

endpackage

// File: rtl/mio_tmo_cnt.sv
// Bus-access watchdog: counts ACCESS cycles and flags the last allowed one.
module mio_tmo_cnt #(
    parameter int TMO = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign tc = (count == 8'(TMO - 1));

endmodule

// File: rtl/mio_arbiter.sv
// Two-requester (CPU, DMA) round-robin arbiter in front of a single memory bus,
// with per-port read-data registers and an ack timeout.
module mio_arbiter
    import mio_pkg::*;
#(
    parameter int AW  = 32,
    parameter int TMO = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_ready,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [31:0]   dma_wdata,
    output logic [31:0]   dma_rdata,
    output logic          dma_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output logic [1:0]    grant,
    output logic          err
);

    mio_state_t state;
    logic       prio_dma;
    logic       tmo_tc;

    mio_tmo_cnt #(.TMO(TMO)) u_tmo (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_IDLE),
        .enable (state == ST_ACCESS),
        .tc     (tmo_tc)
    );

    // prio_dma names who wins the next tie; it flips to the other port on
    // every grant, and starts at CPU so the first tie after reset goes there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            prio_dma  <= 1'b0;
            grant     <= 2'b00;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            cpu_rdata <= 32'd0;
            dma_rdata <= 32'd0;
            cpu_ready <= 1'b0;
            dma_ready <= 1'b0;
            err       <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            dma_ready <= 1'b0;
            err       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_req && (!dma_req || !prio_dma)) begin
                        grant[PORT_CPU] <= 1'b1;
                        prio_dma  <= 1'b1;
                        mem_we    <= cpu_we;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        mem_en    <= 1'b1;
                        state     <= ST_ACCESS;
                    end else if (dma_req) begin
                        grant[PORT_DMA] <= 1'b1;
                        prio_dma  <= 1'b0;
                        mem_we    <= dma_we;
                        mem_addr  <= dma_addr;
                        mem_wdata <= dma_wdata;
                        mem_en    <= 1'b1;
                        state     <= ST_ACCESS;
                    end
                end
                // An ack on the terminal cycle is a real completion, so it is tested first.
                ST_ACCESS: begin
                    if (mem_ack || tmo_tc) begin
                        if (grant[PORT_CPU]) begin
                            cpu_rdata <= mem_ack ? mem_rdata : TMO_PATTERN;
                        end
                        if (grant[PORT_DMA]) begin
                            dma_rdata <= mem_ack ? mem_rdata : TMO_PATTERN;
                        end
                        cpu_ready <= grant[PORT_CPU];
                        dma_ready <= grant[PORT_DMA];
                        err       <= !mem_ack;
                        mem_en    <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    grant <= 2'b00;
                    state <= ST_IDLE;
                end
                default: begin
                    grant  <= 2'b00;
                    mem_en <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mio_arbiter.sv
// Directed bench for mio_arbiter: single accesses, round-robin ties, timeout,
// stray acks, mid-access reset and ack on the terminal-count cycle.
module tb_mio_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        cpu_ready, dma_ready;
    logic        mem_en, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant;
    logic        err;

    int vec_count  = 0;
    int miss_count = 0;
    int en_cycles;

    mio_arbiter #(.AW(32), .TMO(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_ready (dma_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .grant     (grant),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c_req, input logic d_req,
                                 input logic ack, input logic [31:0] rdata);
        cpu_req   = c_req;
        dma_req   = d_req;
        mem_ack   = ack;
        mem_rdata = rdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_count++;
        assert (observed === expected) else begin
            miss_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'd0;
        cpu_wdata = 32'd0;
        dma_we    = 1'b0;
        dma_addr  = 32'd0;
        dma_wdata = 32'd0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_ready", 32'({cpu_ready, dma_ready, err}), 32'd0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 32'd0);
        reset = 1'b0;
        tick();

        // CPU read with ack on the first ACCESS cycle: ready in the third cycle
        cpu_addr = 32'h0000_0010;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("a_grant", 32'(grant), 32'd1);
        checkOutput("a_mem_en", 32'(mem_en), 32'd1);
        checkOutput("a_mem_addr", mem_addr, 32'h0000_0010);
        checkOutput("a_mem_we", 32'(mem_we), 32'd0);
        checkOutput("a_early_ready", 32'(cpu_ready), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1234_5678);
        tick();
        checkOutput("a_cpu_ready", 32'(cpu_ready), 32'd1);
        checkOutput("a_cpu_rdata", cpu_rdata, 32'h1234_5678);
        checkOutput("a_done_mem_en", 32'(mem_en), 32'd0);
        checkOutput("a_dma_ready_err", 32'({dma_ready, err}), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("a_ready_pulse", 32'(cpu_ready), 32'd0);
        checkOutput("a_grant_clr", 32'(grant), 32'd0);

        // Two ties from reset: CPU first, DMA second, one IDLE cycle between
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        checkOutput("b_tie1_grant", 32'(grant), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h1111_1111);
        tick();
        checkOutput("b_cpu_ready", 32'({cpu_ready, dma_ready}), 32'b10);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        checkOutput("b_idle_gap", 32'(grant), 32'd0);
        tick();
        checkOutput("b_tie2_grant", 32'(grant), 32'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h2222_2222);
        tick();
        checkOutput("b_dma_ready", 32'({cpu_ready, dma_ready}), 32'b01);
        checkOutput("b_dma_rdata", dma_rdata, 32'h2222_2222);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        tick();

        // DMA write that never gets an ack
        dma_we    = 1'b1;
        dma_addr  = 32'h0000_0200;
        dma_wdata = 32'hA5A5_A5A5;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        tick();
        checkOutput("c_grant", 32'(grant), 32'd2);
        checkOutput("c_mem_we", 32'(mem_we), 32'd1);
        checkOutput("c_mem_addr", mem_addr, 32'h0000_0200);
        checkOutput("c_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        en_cycles = 0;
        while (mem_en && en_cycles < 40) begin
            en_cycles++;
            tick();
        end
        checkOutput("c_en_cycles", 32'(en_cycles), 32'd16);
        checkOutput("c_ready_err", 32'({cpu_ready, dma_ready, err}), 32'b011);
        checkOutput("c_dma_rdata", dma_rdata, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("c_err_pulse", 32'({dma_ready, err}), 32'd0);
        checkOutput("c_cpu_rdata_hold", cpu_rdata, 32'h1111_1111);

        // Stray ack in IDLE, then a normal CPU read
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hBAD0_BAD0);
        tick();
        tick();
        checkOutput("d_stray_ready", 32'({cpu_ready, dma_ready, mem_en}), 32'd0);
        checkOutput("d_stray_rdata", cpu_rdata, 32'h1111_1111);
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0040;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("d_grant", 32'(grant), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hCAFE_F00D);
        tick();
        checkOutput("d_cpu_ready", 32'(cpu_ready), 32'd1);
        checkOutput("d_cpu_rdata", cpu_rdata, 32'hCAFE_F00D);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        tick();

        // Tie now favours DMA; reset mid-access, then tie goes back to CPU
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        checkOutput("e_grant_dma", 32'(grant), 32'd2);
        reset = 1'b1;
        #1;
        checkOutput("e_rst_grant", 32'(grant), 32'd0);
        checkOutput("e_rst_mem", 32'({mem_en, mem_we}), 32'd0);
        checkOutput("e_rst_addr", mem_addr, 32'd0);
        checkOutput("e_rst_wdata", mem_wdata, 32'd0);
        checkOutput("e_rst_rdata", cpu_rdata | dma_rdata, 32'd0);
        #2;
        reset = 1'b0;
        tick();
        checkOutput("e_after_ready", 32'({cpu_ready, dma_ready}), 32'd0);
        checkOutput("e_tie_cpu", 32'(grant), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h3333_3333);
        tick();
        checkOutput("e_ready", 32'({cpu_ready, dma_ready}), 32'b10);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        tick();

        // CPU write acked on the terminal-count cycle: normal completion
        cpu_we    = 1'b1;
        cpu_addr  = 32'h0000_0080;
        cpu_wdata = 32'h5555_AAAA;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        checkOutput("f_still_access", 32'({mem_en, cpu_ready}), 32'b10);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0F0F_0F0F);
        tick();
        checkOutput("f_ready_err", 32'({cpu_ready, err}), 32'b10);
        checkOutput("f_cpu_rdata", cpu_rdata, 32'h0F0F_0F0F);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        checkOutput("f_idle", 32'({grant, cpu_ready}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/mio_arbiter.md
MIO_ARBITER -- requirements
Module: mio_arbiter

Interface
REQ-001 Parameter AW, 32, address width of all address ports.
REQ-002 Parameter TMO, 16, mem_ack timeout in cycles, legal range 2..255.
REQ-003 clk  in  1  clock, all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 cpu_req  in  1  CPU access request, held until cpu_ready.
REQ-006 cpu_we  in  1  CPU write (1) / read (0).
REQ-007 cpu_addr  in  AW  CPU address.
REQ-008 cpu_wdata  in  32  CPU write data.
REQ-009 cpu_rdata  out  32  CPU read data, valid when cpu_ready.
REQ-010 cpu_ready  out  1  one-cycle completion pulse to CPU (drives MIO_ready).
REQ-011 dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ready  same widths and meaning as the CPU port, for the DMA/peripheral requester.
REQ-012 mem_en  out  1  bus access strobe.
REQ-013 mem_we  out  1  bus write.
REQ-014 mem_addr  out  AW  bus address.
REQ-015 mem_wdata  out  32  bus write data.
REQ-016 mem_rdata  in  32  bus read data, valid with mem_ack.
REQ-017 mem_ack  in  1  bus completion.
REQ-018 grant  out  2  one-hot owner: [0] CPU, [1] DMA, 00 idle.
REQ-019 err  out  1  one-cycle pulse, coincident with ready, on timeout.

Function
REQ-020 States: IDLE, ACCESS, DONE; encoding in shared package.
REQ-021 IDLE: no request -> stay; one request -> grant it, go ACCESS next cycle.
REQ-022 IDLE, both requests: grant the port NOT granted last (round-robin); after reset, CPU wins first tie.
REQ-023 Request inputs, we, addr and wdata sampled into registers on grant; bus outputs driven only from these registers.
REQ-024 ACCESS: mem_en=1, mem_we/addr/wdata from registers; timeout counter increments each cycle.
REQ-025 ACCESS with mem_ack=1 -> latch mem_rdata into the granted port's rdata register, go DONE.
REQ-026 ACCESS, counter reaches TMO-1 without mem_ack -> rdata register = 32'hDEAD_BEEF, err pending, go DONE.
REQ-027 mem_ack and timeout in the same cycle: mem_ack wins, no err.
REQ-028 DONE: granted port's ready=1 for exactly one cycle, err=1 if pending, mem_en=0; next state IDLE, grant cleared.
REQ-029 Minimum latency req->ready = 3 cycles (grant edge, ack edge, DONE) with ack on first ACCESS cycle; no back-to-back grant without an IDLE cycle.
REQ-030 mem_ack outside ACCESS is ignored.
REQ-031 Requests dropped while granted do not abort the access; completion still pulses ready.
REQ-032 rdata outputs hold the last latched value between accesses; non-granted port never sees ready.
REQ-033 Write accesses also complete via mem_ack; rdata is updated with mem_rdata regardless of we.

Reset
REQ-034 reset asserted at any time (including mid-ACCESS) -> state IDLE, grant=00, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_ready=dma_ready=0, err=0, cpu_rdata=dma_rdata=0, counter=0, round-robin pointer = CPU.
REQ-035 An access in flight at reset is discarded; no ready pulse follows.

Structure
REQ-036 State encoding, port index constants and the 32'hDEAD_BEEF timeout pattern live in the shared MIO package.
REQ-037 The timeout counter is the one natural sub-module: mio_tmo_cnt (clear, enable, terminal-count output).

Verification
REQ-038 CPU read 0x0000_0010, mem_ack 1 cycle after mem_en, mem_rdata=0x1234_5678 -> cpu_ready pulse at cycle 3, cpu_rdata=0x1234_5678, grant=01 during access.
REQ-039 cpu_req and dma_req together from reset, twice in a row -> first grant CPU, second grant DMA, one IDLE cycle between.
REQ-040 DMA write addr 0x0000_0200 data 0xA5A5_A5A5, no mem_ack -> mem_en high TMO cycles, dma_ready and err pulse together, dma_rdata=0xDEAD_BEEF.
REQ-041 mem_ack asserted in IDLE, then CPU read -> stray ack ignored, normal completion.
REQ-042 reset pulse mid-ACCESS -> all outputs to reset values within the same cycle, no ready afterward, next tie goes to CPU.
REQ-043 mem_ack on the terminal-count cycle -> normal completion, err=0.
